// File: rtl/mbus_wake_pkg.sv
// Shared types and default timing constants for the MBus wake/interrupt burst sequencer.
package mbus_wake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RESTORE = 2'd2,
    GAP     = 2'd3
  } wake_state_e;

  localparam int WAKE_TOGGLES  = 3;
  localparam int WAKE_HALF_CYC = 4;
  localparam int WAKE_GAP_CYC  = 8;

endpackage

// File: rtl/mbus_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module mbus_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic                       win_valid
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] idx;
  logic          hit;

  // Scan from the pointer upward; the first hit locks out all later candidates.
  always_comb begin
    win_oh    = {NUM_REQ{1'b0}};
    win_valid = 1'b0;
    idx       = {PW{1'b0}};
    hit       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx         = PW'((int'(ptr) + i) % NUM_REQ);
      hit         = !win_valid && req[idx];
      win_oh[idx] = win_oh[idx] | hit;
      win_valid   = win_valid | hit;
    end
  end

endmodule

// File: rtl/mbus_wake_sequencer.sv
// Grants one requester at a time and drives the DATA toggle burst that wakes or
// interrupts a sleeping MBus member while bus CLK is held high.
module mbus_wake_sequencer
  import mbus_wake_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_TOGGLES = WAKE_TOGGLES,
  parameter int HALF_CYC    = WAKE_HALF_CYC,
  parameter int GAP_CYC     = WAKE_GAP_CYC
) (
  input  logic               CLK_SYS,
  input  logic               negp_reset,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               DOUT,
  output logic               DOUT_EN,
  output logic               DONE,
  output logic               BUSY
);

  localparam int PW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PHW     = $clog2(2 * NUM_TOGGLES + 2);

  localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CYC);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(2 * NUM_TOGGLES);

  wake_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PHW-1:0]     ph_q, ph_d;
  logic [PW-1:0]      ptr_q, ptr_d, ptr_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               dout_q, dout_d;
  logic               den_q, den_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic               arb_valid;

  mbus_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (REQ),
    .ptr       (ptr_q),
    .win_oh    (arb_oh),
    .win_valid (arb_valid)
  );

  // Pointer moves to the slot just after the winner, wrapping to zero.
  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      ptr_nxt = arb_oh[i] ? ((i == NUM_REQ - 1) ? {PW{1'b0}} : PW'(i + 1)) : ptr_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    dout_d  = dout_q;
    den_d   = den_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = DRIVE;
          gnt_d   = arb_oh;
          ptr_d   = ptr_nxt;
          dout_d  = 1'b0;
          den_d   = 1'b1;
          cnt_d   = {CW{1'b0}};
          ph_d    = {PHW{1'b0}};
        end else begin
          gnt_d  = {NUM_REQ{1'b0}};
          dout_d = 1'b1;
          den_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CW{1'b0}};
          // Odd number of half-periods: the burst starts and ends low.
          if (ph_q == PH_LAST) begin
            state_d = RESTORE;
            ph_d    = {PHW{1'b0}};
            dout_d  = 1'b1;
          end else begin
            ph_d   = ph_q + PHW'(1);
            dout_d = ~dout_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESTORE: begin
        if (cnt_q == HALF_LAST) begin
          state_d = GAP;
          cnt_d   = {CW{1'b0}};
          dout_d  = 1'b1;
          den_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        // First GAP cycle carries DONE with GNT; GAP_CYC grant-free cycles follow.
        gnt_d  = {NUM_REQ{1'b0}};
        dout_d = 1'b1;
        den_d  = 1'b0;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        ph_d    = {PHW{1'b0}};
        gnt_d   = {NUM_REQ{1'b0}};
        dout_d  = 1'b1;
        den_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_SYS or posedge negp_reset) begin
    if (negp_reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      ph_q    <= {PHW{1'b0}};
      ptr_q   <= {PW{1'b0}};
      gnt_q   <= {NUM_REQ{1'b0}};
      dout_q  <= 1'b1;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT     = gnt_q;
  assign DOUT    = dout_q;
  assign DOUT_EN = den_q;
  assign DONE    = done_q;
  assign BUSY    = busy_q;

endmodule
